// File: rtl/id_gen_if.sv
// Request, character-stream and status signals for the identifier stream generator.
// slave is the generator side, master is the requester/sink side.
interface id_gen_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] n_letters;
  logic [CNT_W-1:0] n_digits;
  logic [4:0]       letter_idx;
  logic [3:0]       digit_idx;
  logic             ready;
  logic [7:0]       chr;
  logic             valid;
  logic             exp_out;
  logic             busy;
  logic             done;
  logic             err;

  modport slave (
    input  start, n_letters, n_digits, letter_idx, digit_idx, ready,
    output chr, valid, exp_out, busy, done, err
  );

  modport master (
    output start, n_letters, n_digits, letter_idx, digit_idx, ready,
    input  chr, valid, exp_out, busy, done, err
  );
endinterface

// File: rtl/id_gen.sv
// Emits a letter run followed by a digit run over a valid/ready stream, with the
// identifier-recognizer output expected after each character.
module id_gen #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned UPPER = 0
) (
  input logic     clk_i,
  input logic     reset_i,
  id_gen_if.slave bus
);
  localparam logic [7:0] LetterBase = (UPPER != 0) ? 8'd65 : 8'd97;
  localparam logic [7:0] DigitBase  = 8'd48;

  typedef enum logic [1:0] {StIdle, StLet, StDig, StFin} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] let_cnt_q, dig_cnt_q;
  logic [4:0]       let_off_q;
  logic [3:0]       dig_off_q;
  logic [7:0]       char_q;
  logic             valid_q, exp_q, busy_q, done_q, err_q;

  logic [4:0] let_start, let_next;
  logic [3:0] dig_start, dig_next;
  logic       xfer;

  always_comb begin
    let_start = (bus.letter_idx > 5'd25) ? bus.letter_idx - 5'd26 : bus.letter_idx;
    dig_start = (bus.digit_idx > 4'd9) ? bus.digit_idx - 4'd10 : bus.digit_idx;
    let_next  = (let_off_q == 5'd25) ? 5'd0 : let_off_q + 5'd1;
    dig_next  = (dig_off_q == 4'd9) ? 4'd0 : dig_off_q + 4'd1;
    xfer      = valid_q & bus.ready;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      let_cnt_q <= '0;
      dig_cnt_q <= '0;
      let_off_q <= '0;
      dig_off_q <= '0;
      char_q    <= '0;
      valid_q   <= 1'b0;
      exp_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // The done cycle itself does not accept a new request.
          if (bus.start && !done_q) begin
            if (bus.n_letters == '0) begin
              err_q <= 1'b1;
            end else begin
              let_cnt_q <= bus.n_letters;
              dig_cnt_q <= bus.n_digits;
              let_off_q <= let_start;
              dig_off_q <= dig_start;
              char_q    <= LetterBase + {3'b000, let_start};
              exp_q     <= 1'b0;
              valid_q   <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= StLet;
            end
          end
        end
        StLet: begin
          if (xfer) begin
            if (let_cnt_q == CNT_W'(1)) begin
              if (dig_cnt_q != '0) begin
                char_q  <= DigitBase + {4'b0000, dig_off_q};
                exp_q   <= 1'b1;
                state_q <= StDig;
              end else begin
                valid_q <= 1'b0;
                state_q <= StFin;
              end
            end else begin
              let_cnt_q <= let_cnt_q - CNT_W'(1);
              let_off_q <= let_next;
              char_q    <= LetterBase + {3'b000, let_next};
            end
          end
        end
        StDig: begin
          if (xfer) begin
            if (dig_cnt_q == CNT_W'(1)) begin
              valid_q <= 1'b0;
              state_q <= StFin;
            end else begin
              dig_cnt_q <= dig_cnt_q - CNT_W'(1);
              dig_off_q <= dig_next;
              char_q    <= DigitBase + {4'b0000, dig_next};
            end
          end
        end
        StFin: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          exp_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.chr     = char_q;
  assign bus.valid   = valid_q;
  assign bus.exp_out = exp_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_id_gen.sv
// Directed bench for id_gen: lowercase and uppercase instances driven by one request,
// observed one at a time through a select.
module tb_id_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] n_letters = '0, n_digits = '0;
  logic [4:0] letter_idx = '0;
  logic [3:0] digit_idx = '0;
  logic       ready = 1'b1;
  bit         sel = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_chr[$];
  logic       q_exp[$];
  int         done_cyc, vcycles, unstable;
  logic       busy_at_done;
  bit         err_seen;

  always #5 clk = ~clk;

  id_gen_if #(.CNT_W(4)) lo_if ();
  id_gen_if #(.CNT_W(4)) up_if ();

  assign lo_if.start = start;       assign up_if.start = start;
  assign lo_if.n_letters = n_letters;   assign up_if.n_letters = n_letters;
  assign lo_if.n_digits = n_digits;     assign up_if.n_digits = n_digits;
  assign lo_if.letter_idx = letter_idx; assign up_if.letter_idx = letter_idx;
  assign lo_if.digit_idx = digit_idx;   assign up_if.digit_idx = digit_idx;
  assign lo_if.ready = ready;       assign up_if.ready = ready;

  id_gen #(.CNT_W(4), .UPPER(0)) dut_lo (.clk_i(clk), .reset_i(rst), .bus(lo_if));
  id_gen #(.CNT_W(4), .UPPER(1)) dut_up (.clk_i(clk), .reset_i(rst), .bus(up_if));

  logic [7:0] o_chr;
  logic       o_valid, o_exp, o_busy, o_done, o_err;
  assign o_chr   = sel ? up_if.chr     : lo_if.chr;
  assign o_valid = sel ? up_if.valid   : lo_if.valid;
  assign o_exp   = sel ? up_if.exp_out : lo_if.exp_out;
  assign o_busy  = sel ? up_if.busy    : lo_if.busy;
  assign o_done  = sel ? up_if.done    : lo_if.done;
  assign o_err   = sel ? up_if.err     : lo_if.err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input int nl, input int nd, input int li, input int di);
    n_letters  = 4'(nl);
    n_digits   = 4'(nd);
    letter_idx = 5'(li);
    digit_idx  = 4'(di);
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Records transfers until done or budget; cycle 1 is the one after the start edge.
  task automatic collect(input int budget, input bit stall, input int inj_at);
    int         sc = 0;
    bit         holding = 0;
    logic [7:0] hold_c = '0;
    logic       hold_e = 1'b0;
    q_chr.delete();
    q_exp.delete();
    done_cyc = -1; vcycles = 0; unstable = 0; busy_at_done = 1'b1; err_seen = 0;
    for (int c = 1; c <= budget; c++) begin
      ready = stall ? (sc == 2) : 1'b1;
      start = (c == inj_at);
      if (c == inj_at) begin
        n_letters = 4'd5; n_digits = 4'd1; letter_idx = 5'd10; digit_idx = 4'd0;
      end
      if (o_err === 1'b1) err_seen = 1;
      if (holding && (o_chr !== hold_c || o_exp !== hold_e || o_valid !== 1'b1)) unstable++;
      holding = 0;
      if (o_valid === 1'b1) begin
        vcycles++;
        if (ready) begin
          q_chr.push_back(o_chr);
          q_exp.push_back(o_exp);
          sc = 0;
        end else begin
          holding = 1; hold_c = o_chr; hold_e = o_exp; sc++;
        end
      end
      if (o_done === 1'b1) begin
        done_cyc = c;
        busy_at_done = o_busy;
        break;
      end
      tick();
    end
    start = 1'b0;
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (o_chr !== 8'd0) begin errors++; $display("FAIL reset_char got %0d want 0", o_chr); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_exp !== 1'b0) begin errors++; $display("FAIL reset_exp got %b want 0", o_exp); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", o_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ec[5] = '{8'd97, 8'd98, 8'd55, 8'd56, 8'd57};
    logic       ee[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    sel = 1'b0;
    start_req(2, 3, 0, 7);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", o_busy); end
    collect(20, 1'b0, 0);
    checks++; if (q_chr.size() != 5) begin errors++; $display("FAIL b2b_count got %0d want 5", q_chr.size()); end
    for (int i = 0; i < 5 && i < q_chr.size(); i++) begin
      checks++; if (q_chr[i] !== ec[i]) begin errors++; $display("FAIL b2b_char[%0d] got %0d want %0d", i, q_chr[i], ec[i]); end
      checks++; if (q_exp[i] !== ee[i]) begin errors++; $display("FAIL b2b_exp[%0d] got %b want %b", i, q_exp[i], ee[i]); end
    end
    checks++; if (vcycles != 5) begin errors++; $display("FAIL b2b_valid_cycles got %0d want 5", vcycles); end
    checks++; if (done_cyc != 7) begin errors++; $display("FAIL b2b_done_cycle got %0d want 7", done_cyc); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL b2b_busy_at_done got %b want 0", busy_at_done); end
    tick();
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL b2b_done_width got %b want 0", o_done); end
  endtask

  task automatic test_upper_wrap();
    logic [7:0] ec[4] = '{8'd89, 8'd90, 8'd65, 8'd66};
    sel = 1'b1;
    start_req(4, 0, 24, 0);
    collect(20, 1'b0, 0);
    checks++; if (q_chr.size() != 4) begin errors++; $display("FAIL up_count got %0d want 4", q_chr.size()); end
    for (int i = 0; i < 4 && i < q_chr.size(); i++) begin
      checks++; if (q_chr[i] !== ec[i]) begin errors++; $display("FAIL up_char[%0d] got %0d want %0d", i, q_chr[i], ec[i]); end
      checks++; if (q_exp[i] !== 1'b0) begin errors++; $display("FAIL up_exp[%0d] got %b want 0", i, q_exp[i]); end
    end
    checks++; if (done_cyc != 6) begin errors++; $display("FAIL up_done_cycle got %0d want 6", done_cyc); end
    sel = 1'b0;
    tick(); tick();
  endtask

  task automatic test_stall();
    sel = 1'b0;
    start_req(1, 1, 0, 0);
    collect(30, 1'b1, 0);
    checks++; if (q_chr.size() != 2) begin errors++; $display("FAIL stall_count got %0d want 2", q_chr.size()); end
    if (q_chr.size() == 2) begin
      checks++; if (q_chr[0] !== 8'd97) begin errors++; $display("FAIL stall_char0 got %0d want 97", q_chr[0]); end
      checks++; if (q_chr[1] !== 8'd48) begin errors++; $display("FAIL stall_char1 got %0d want 48", q_chr[1]); end
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL stall_hold got %0d changes want 0", unstable); end
    checks++; if (vcycles != 6) begin errors++; $display("FAIL stall_valid_cycles got %0d want 6", vcycles); end
    checks++; if (done_cyc != 8) begin errors++; $display("FAIL stall_done_cycle got %0d want 8", done_cyc); end
    tick(); tick();
  endtask

  task automatic test_err_and_busy_start();
    int seen_valid = 0;
    logic [7:0] ec[4] = '{8'd100, 8'd101, 8'd53, 8'd54};
    sel = 1'b0;
    start_req(0, 3, 0, 0);
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b want 1", o_err); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL err_busy got %b want 0", o_busy); end
    tick();
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_width got %b want 0", o_err); end
    for (int i = 0; i < 5; i++) begin
      if (o_valid !== 1'b0) seen_valid++;
      tick();
    end
    checks++; if (seen_valid != 0) begin errors++; $display("FAIL err_valid got %0d cycles want 0", seen_valid); end
    // Out-of-range offsets reduce to 'd' and '5'; a start at cycle 2 must be ignored.
    start_req(2, 2, 29, 15);
    collect(20, 1'b0, 2);
    checks++; if (q_chr.size() != 4) begin errors++; $display("FAIL busy_start_count got %0d want 4", q_chr.size()); end
    for (int i = 0; i < 4 && i < q_chr.size(); i++) begin
      checks++; if (q_chr[i] !== ec[i]) begin errors++; $display("FAIL busy_start_char[%0d] got %0d want %0d", i, q_chr[i], ec[i]); end
    end
    checks++; if (err_seen != 0) begin errors++; $display("FAIL busy_start_err got %0d want 0", err_seen); end
    checks++; if (done_cyc != 6) begin errors++; $display("FAIL busy_start_done got %0d want 6", done_cyc); end
    tick(); tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b want 0", o_valid); end
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    logic [7:0] ec[3] = '{8'd122, 8'd57, 8'd48};
    sel = 1'b0;
    ready = 1'b1;
    start_req(2, 4, 0, 0);
    tick(); tick(); tick();
    checks++; if (o_chr !== 8'd49) begin errors++; $display("FAIL mid_char got %0d want 49", o_chr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", o_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", o_busy); end
    for (int i = 0; i < 10; i++) begin
      if (o_done !== 1'b0 || o_valid !== 1'b0) seen_done++;
      tick();
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", seen_done); end
    start_req(1, 2, 25, 9);
    collect(20, 1'b0, 0);
    checks++; if (q_chr.size() != 3) begin errors++; $display("FAIL fresh_count got %0d want 3", q_chr.size()); end
    for (int i = 0; i < 3 && i < q_chr.size(); i++) begin
      checks++; if (q_chr[i] !== ec[i]) begin errors++; $display("FAIL fresh_char[%0d] got %0d want %0d", i, q_chr[i], ec[i]); end
    end
    checks++; if (done_cyc != 5) begin errors++; $display("FAIL fresh_done got %0d want 5", done_cyc); end
    tick(); tick();
  endtask

  task automatic test_long_recognizer();
    int         rs = 0;
    logic [7:0] want;
    bit         is_let, is_dig, rec_out;
    sel = 1'b0;
    start_req(15, 15, 0, 3);
    collect(40, 1'b0, 0);
    checks++; if (q_chr.size() != 30) begin errors++; $display("FAIL long_count got %0d want 30", q_chr.size()); end
    checks++; if (done_cyc != 32) begin errors++; $display("FAIL long_done got %0d want 32", done_cyc); end
    for (int i = 0; i < 30 && i < q_chr.size(); i++) begin
      want = (i < 15) ? 8'(97 + i) : 8'(48 + ((3 + i - 15) % 10));
      checks++; if (q_chr[i] !== want) begin errors++; $display("FAIL long_char[%0d] got %0d want %0d", i, q_chr[i], want); end
      // Recognizer: letter first, then letters/digits; output high after a digit.
      is_let = (q_chr[i] >= 8'd97 && q_chr[i] <= 8'd122) || (q_chr[i] >= 8'd65 && q_chr[i] <= 8'd90);
      is_dig = (q_chr[i] >= 8'd48 && q_chr[i] <= 8'd57);
      if (rs == 0) rs = is_let ? 1 : 2;
      else if (rs == 1) rs = (is_let || is_dig) ? 1 : 2;
      rec_out = (rs == 1) && is_dig;
      checks++; if (q_exp[i] !== rec_out) begin errors++; $display("FAIL long_rec[%0d] got %b want %b", i, q_exp[i], rec_out); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_upper_wrap();
    test_stall();
    test_err_and_busy_start();
    test_reset_mid();
    test_long_recognizer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
